sha256_msg_padder: RTL

- Transmit side of the SHA-256 core's message-load interface.
- Accepts a raw byte stream, applies FIPS 180-4 padding, and appends the 64-bit big-endian bit length.
- Packs bytes big-endian into 32-bit words and delivers each 512-bit block as 16 valid-qualified words.
- Pulses start_o once per block and waits for core_done_i before sending the next block.

---
 rtl/sha256_msg_padder.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/sha256_msg_padder.sv
`default_nettype none
// ============================================================================
// sha256_msg_padder : byte stream -> padded, length-tagged 512-bit blocks
//   delivered as 16 big-endian words per block, one start_o per block.
//   Optional: SHA256_PAD_BLKCNT_EN adds blk_cnt_o (blocks started).
// Revision: 1.0
// ============================================================================
module sha256_msg_padder #(
    parameter int LEN_W     = 64,
    parameter int START_GAP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data_i,
    input  logic        in_valid_i,
    input  logic        in_last_i,
    output logic        in_ready_o,
    output logic        start_o,
    output logic [31:0] msg_word_o,
    output logic        msg_word_valid_o,
    output logic        first_block_o,
    input  logic        core_done_i,
    output logic        busy_o,
`ifdef SHA256_PAD_BLKCNT_EN
    output logic [15:0] blk_cnt_o,
`endif
    output logic        msg_done_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAD80 = 3'd3,
        ST_ZERO  = 3'd4,
        ST_LEN   = 3'd5,
        ST_WAIT  = 3'd6
    } state_t;

    localparam logic [2:0]       GAP_LAST = 3'(START_GAP);
    localparam logic [LEN_W-1:0] LEN_INC  = LEN_W'(8);

    state_t             state_q, state_d;
    state_t             resume_q, resume_d;
    logic [5:0]         byte_ptr_q, byte_ptr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [31:0]        word_q, word_d;
    logic               ovf_q, ovf_d;
    logic [2:0]         gap_q, gap_d;
    logic               first_q, first_d;
    logic               last_blk_q, last_blk_d;
    logic               start_q, start_d;
    logic               word_valid_q, word_valid_d;
    logic               msg_done_q, msg_done_d;

    logic               emit;
    logic [7:0]         emit_byte;
    logic [63:0]        len_ext;
    logic [2:0]         len_idx;
    logic [7:0]         len_byte;

    // The length field is always 64 bits on the wire; bits above LEN_W are zero.
    assign len_ext  = 64'(len_q);
    assign len_idx  = 3'd7 - byte_ptr_q[2:0];
    assign len_byte = len_ext[{len_idx, 3'b000} +: 8];

    always_comb begin
        state_d      = state_q;
        resume_d     = resume_q;
        byte_ptr_d   = byte_ptr_q;
        len_d        = len_q;
        word_d       = word_q;
        ovf_d        = ovf_q;
        gap_d        = gap_q;
        first_d      = first_q;
        last_blk_d   = last_blk_q;
        start_d      = 1'b0;
        word_valid_d = 1'b0;
        msg_done_d   = 1'b0;
        emit         = 1'b0;
        emit_byte    = 8'h00;

        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    len_d      = '0;
                    first_d    = 1'b1;
                    last_blk_d = 1'b0;
                    resume_d   = ST_DATA;
                    start_d    = 1'b1;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                byte_ptr_d = 6'd0;
                // A pad byte landing at 63 leaves ovf set; a fresh block must start clean.
                ovf_d      = 1'b0;
                if (gap_q == GAP_LAST) begin
                    gap_d   = 3'd0;
                    state_d = resume_q;
                end else begin
                    gap_d = gap_q + 3'd1;
                end
            end
            ST_DATA: begin
                if (in_valid_i) begin
                    emit      = 1'b1;
                    emit_byte = in_data_i;
                    len_d     = len_q + LEN_INC;
                    if (byte_ptr_q == 6'd63) begin
                        state_d  = ST_WAIT;
                        resume_d = in_last_i ? ST_PAD80 : ST_DATA;
                    end else if (in_last_i) begin
                        state_d = ST_PAD80;
                    end
                end
            end
            ST_PAD80: begin
                emit      = 1'b1;
                emit_byte = 8'h80;
                if (byte_ptr_q == 6'd55) begin
                    state_d = ST_LEN;
                end else if (byte_ptr_q == 6'd63) begin
                    ovf_d    = 1'b1;
                    state_d  = ST_WAIT;
                    resume_d = ST_ZERO;
                end else begin
                    if (byte_ptr_q >= 6'd56) begin
                        ovf_d = 1'b1;
                    end
                    state_d = ST_ZERO;
                end
            end
            ST_ZERO: begin
                emit = 1'b1;
                if (byte_ptr_q == 6'd55 && !ovf_q) begin
                    state_d = ST_LEN;
                end else if (byte_ptr_q == 6'd63) begin
                    ovf_d    = 1'b0;
                    state_d  = ST_WAIT;
                    resume_d = ST_ZERO;
                end
            end
            ST_LEN: begin
                emit      = 1'b1;
                emit_byte = len_byte;
                if (byte_ptr_q == 6'd63) begin
                    last_blk_d = 1'b1;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (core_done_i) begin
                    first_d = 1'b0;
                    if (last_blk_q) begin
                        last_blk_d = 1'b0;
                        msg_done_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        start_d = 1'b1;
                        state_d = ST_START;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (emit) begin
            word_d       = {word_q[23:0], emit_byte};
            byte_ptr_d   = byte_ptr_q + 6'd1;
            word_valid_d = (byte_ptr_q[1:0] == 2'd3);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            resume_q     <= ST_DATA;
            byte_ptr_q   <= 6'd0;
            len_q        <= '0;
            word_q       <= 32'd0;
            ovf_q        <= 1'b0;
            gap_q        <= 3'd0;
            first_q      <= 1'b0;
            last_blk_q   <= 1'b0;
            start_q      <= 1'b0;
            word_valid_q <= 1'b0;
            msg_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            resume_q     <= resume_d;
            byte_ptr_q   <= byte_ptr_d;
            len_q        <= len_d;
            word_q       <= word_d;
            ovf_q        <= ovf_d;
            gap_q        <= gap_d;
            first_q      <= first_d;
            last_blk_q   <= last_blk_d;
            start_q      <= start_d;
            word_valid_q <= word_valid_d;
            msg_done_q   <= msg_done_d;
        end
    end

    assign in_ready_o       = (state_q == ST_DATA);
    assign busy_o           = (state_q != ST_IDLE);
    assign start_o          = start_q;
    assign msg_word_o       = word_q;
    assign msg_word_valid_o = word_valid_q;
    assign first_block_o    = first_q;
    assign msg_done_o       = msg_done_q;

`ifdef SHA256_PAD_BLKCNT_EN
    logic [15:0] blk_cnt_q, blk_cnt_d;

    always_comb begin
        blk_cnt_d = (state_q == ST_IDLE) ? 16'd0 : blk_cnt_q;
        if (start_d && blk_cnt_d != 16'hFFFF) begin
            blk_cnt_d = blk_cnt_d + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_q <= 16'd0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign blk_cnt_o = blk_cnt_q;
`else
    // Block counting not built in this configuration.
`endif

endmodule
`default_nettype wire
